// File: rtl/i2c_regmap_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_regmap_slave                                             |
// | Description : I2C target with 8-bit register map (ID, scratch, LED, SW,    |
// |               optional SPI status when I2C_SPI_STATUS_EN is defined).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_regmap_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter logic [7:0] DEVICE_ID  = 8'hA7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oe,
    output logic [7:0] led_out,
    input  logic [7:0] sw_in,
    input  logic       spi_active,
    input  logic [7:0] spi_rx_byte
);
    localparam logic [7:0] c_version = 8'h01;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_REG      = 4'd3,
        S_REG_ACK  = 4'd4,
        S_WDATA    = 4'd5,
        S_WACK     = 4'd6,
        S_RDATA    = 4'd7,
        S_RACK     = 4'd8
    } state_t;

    state_t     r_state;
    logic [1:0] r_scl_sync, r_sda_sync;
    logic       r_scl_prev, r_sda_prev;
    logic [7:0] r_sw_meta, r_sw_sync;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift, r_ptr;
    logic       r_full, r_rw, r_mack, r_sda_oe;
    logic [7:0] r_scratch0, r_scratch1, r_led;

    logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_wr_en;
    logic [7:0] w_wr_byte, w_rd_addr, w_rd_data;

    // Idle bus level is high, so synchronizers reset to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_sw_meta  <= 8'h00;
            r_sw_sync  <= 8'h00;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
            r_sw_meta  <= sw_in;
            r_sw_sync  <= r_sw_meta;
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_wr_byte  = {r_shift[6:0], w_sda};
    assign w_wr_en    = (r_state == S_WDATA) && w_scl_rise && (r_bit_cnt == 3'd7);
    // After a master ACK the next byte comes from the incremented pointer.
    assign w_rd_addr  = (r_state == S_RACK) ? r_ptr + 8'd1 : r_ptr;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            8'h00:   w_rd_data = DEVICE_ID;
            8'h01:   w_rd_data = c_version;
            8'h05:   w_rd_data = r_scratch0;
            8'h06:   w_rd_data = r_scratch1;
            8'h20:   w_rd_data = r_led;
            8'h21:   w_rd_data = r_sw_sync;
`ifdef I2C_SPI_STATUS_EN
            8'h30:   w_rd_data = {7'b0, spi_active};
            8'h31:   w_rd_data = spi_rx_byte;
`endif
            default: w_rd_data = 8'h00;
        endcase
    end

`ifndef I2C_SPI_STATUS_EN
    logic w_spi_unused;
    assign w_spi_unused = ^{spi_active, spi_rx_byte};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scratch0 <= 8'h00;
            r_scratch1 <= 8'h00;
            r_led      <= 8'h00;
        end else if (w_wr_en) begin
            case (r_ptr)
                8'h05:   r_scratch0 <= w_wr_byte;
                8'h06:   r_scratch1 <= w_wr_byte;
                8'h20:   r_led      <= w_wr_byte;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_ptr     <= 8'h00;
            r_full    <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else if (w_start) begin
            r_state   <= S_ADDR;
            r_bit_cnt <= 3'd0;
            r_full    <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_full    <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (w_scl_rise) begin
                        r_shift   <= w_wr_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_full <= 1'b1;
                            if (r_state == S_WDATA)
                                r_ptr <= r_ptr + 8'd1;
                        end
                    end else if (w_scl_fall && r_full) begin
                        r_full    <= 1'b0;
                        r_bit_cnt <= 3'd0;
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                r_rw     <= r_shift[0];
                                r_sda_oe <= 1'b1;
                                r_state  <= S_ADDR_ACK;
                            end else begin
                                r_state  <= S_IDLE;
                            end
                        end else if (r_state == S_REG) begin
                            r_ptr    <= r_shift;
                            r_sda_oe <= 1'b1;
                            r_state  <= S_REG_ACK;
                        end else begin
                            r_sda_oe <= 1'b1;
                            r_state  <= S_WACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        r_bit_cnt <= 3'd0;
                        if (r_rw) begin
                            r_shift  <= w_rd_data;
                            r_sda_oe <= ~w_rd_data[7];
                            r_state  <= S_RDATA;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= S_REG;
                        end
                    end
                end
                S_REG_ACK, S_WACK: begin
                    if (w_scl_fall) begin
                        r_sda_oe <= 1'b0;
                        r_state  <= S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_RACK;
                        end else begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_sda_oe  <= ~r_shift[6];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_RACK: begin
                    if (w_scl_rise) begin
                        r_mack <= ~w_sda;
                    end else if (w_scl_fall) begin
                        if (r_mack) begin
                            r_ptr     <= r_ptr + 8'd1;
                            r_shift   <= w_rd_data;
                            r_sda_oe  <= ~w_rd_data[7];
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_RDATA;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_o   = 1'b0;
    assign sda_oe  = r_sda_oe;
    assign led_out = r_led;

endmodule
`default_nettype wire

// File: tb/tb_i2c_regmap_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_regmap_slave                                          |
// | Description : Bit-banged I2C master bench with read-data scoreboard.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_regmap_slave;
    localparam int Q = 100;

`ifdef I2C_SPI_STATUS_EN
    localparam logic [7:0] c_exp30 = 8'h01;
    localparam logic [7:0] c_exp31 = 8'h9C;
`else
    localparam logic [7:0] c_exp30 = 8'h00;
    localparam logic [7:0] c_exp31 = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] sw_in = 8'h5A;
    logic       spi_active = 1'b1;
    logic [7:0] spi_rx_byte = 8'h9C;
    logic       sda_o, sda_oe, sda_bus;
    logic [7:0] led_out;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_regmap_slave dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_o       (sda_o),
        .sda_oe      (sda_oe),
        .led_out     (led_out),
        .sw_in       (sw_in),
        .spi_active  (spi_active),
        .spi_rx_byte (spi_rx_byte)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SDA may only move while SCL is low outside reset.
    logic r_prev_oe = 1'b0;
    always @(negedge clk) begin
        if (!rst && (sda_oe !== r_prev_oe)) begin
            total++;
            if (scl_m) begin
                bad++;
                $display("FAIL sda_edge_scl_high: scl=%b required scl=0", scl_m);
            end
        end
        r_prev_oe = sda_oe;
    end

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; #Q;
            scl_m = 1'b1; #(2*Q);
            scl_m = 1'b0; #Q;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        ack = ~sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        d = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #Q; scl_m = 1'b1;
            #Q; d = {d[6:0], sda_bus};
            #Q; scl_m = 1'b0;
        end
        #Q; sda_m = ~ack;
        #Q; scl_m = 1'b1;
        #(2*Q); scl_m = 1'b0;
        #Q; sda_m = 1'b1;
    endtask

    task automatic read_pop(input logic ack);
        logic [7:0] d;
        read_byte(ack, d);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got %h expected none", d);
        end else begin
            check("rd_data", d, exp_q.pop_front());
        end
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data);
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack); check("wr_addr_ack", {7'b0, ack}, 8'h01);
        write_byte(addr, ack);  check("wr_reg_ack", {7'b0, ack}, 8'h01);
        write_byte(data, ack);  check("wr_data_ack", {7'b0, ack}, 8'h01);
        i2c_stop();
    endtask

    task automatic rd_regs(input logic [7:0] addr, input int n);
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack); check("rd_waddr_ack", {7'b0, ack}, 8'h01);
        write_byte(addr, ack);  check("rd_reg_ack", {7'b0, ack}, 8'h01);
        i2c_start();
        write_byte(8'hA1, ack); check("rd_raddr_ack", {7'b0, ack}, 8'h01);
        for (int i = 0; i < n; i++) read_pop(i != n - 1);
        i2c_stop();
    endtask

    initial begin
        logic ack;
        vecs[0]  = '{8'h05, 1'b1, 8'h55, 8'h55};
        vecs[1]  = '{8'h06, 1'b1, 8'h3C, 8'h3C};
        vecs[2]  = '{8'h20, 1'b1, 8'hF0, 8'hF0};
        vecs[3]  = '{8'h01, 1'b0, 8'h00, 8'h01};
        vecs[4]  = '{8'h00, 1'b1, 8'hFF, 8'hA7};
        vecs[5]  = '{8'h01, 1'b1, 8'h33, 8'h01};
        vecs[6]  = '{8'h40, 1'b1, 8'h12, 8'h00};
        vecs[7]  = '{8'h21, 1'b0, 8'h00, 8'h5A};
        vecs[8]  = '{8'h30, 1'b0, 8'h00, c_exp30};
        vecs[9]  = '{8'h31, 1'b0, 8'h00, c_exp31};
        vecs[10] = '{8'h21, 1'b1, 8'h00, 8'h5A};
        vecs[11] = '{8'hFF, 1'b1, 8'h77, 8'h00};

        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_oe", {7'b0, sda_oe}, 8'h00);
        check("rst_sda_o", {7'b0, sda_o}, 8'h00);
        check("rst_led", led_out, 8'h00);
        @(negedge clk) rst = 1'b0;
        #(4*Q);

        // Identification read with pointer set by a write phase.
        exp_q.push_back(8'hA7);
        rd_regs(8'h00, 1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                wr_reg(vecs[i].addr, vecs[i].wdata);
                #500;
                if (vecs[i].addr == 8'h20) check("led_after_stop", led_out, vecs[i].wdata);
                #500;
            end
            exp_q.push_back(vecs[i].exp);
            rd_regs(vecs[i].addr, 1);
        end

        // Pointer wraps 0xFF -> 0x00 during a burst read.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hA7);
        rd_regs(8'hFF, 2);

        // Burst write with auto-increment, read back as a burst.
        i2c_start();
        write_byte(8'hA0, ack); check("bw_addr_ack", {7'b0, ack}, 8'h01);
        write_byte(8'h05, ack); check("bw_reg_ack", {7'b0, ack}, 8'h01);
        write_byte(8'h11, ack); check("bw_d0_ack", {7'b0, ack}, 8'h01);
        write_byte(8'h22, ack); check("bw_d1_ack", {7'b0, ack}, 8'h01);
        i2c_stop();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        rd_regs(8'h05, 2);

        // Wrong address: NACKed, later bytes ignored.
        i2c_start();
        write_byte(8'hA2, ack); check("bad_addr_nack", {7'b0, ack}, 8'h00);
        write_byte(8'h05, ack); check("bad_reg_nack", {7'b0, ack}, 8'h00);
        write_byte(8'hEE, ack); check("bad_data_nack", {7'b0, ack}, 8'h00);
        i2c_stop();
        check("bad_led_kept", led_out, 8'hF0);
        exp_q.push_back(8'h11);
        rd_regs(8'h05, 1);

        // STOP mid-byte discards the partial write.
        i2c_start();
        write_byte(8'hA0, ack); check("pw_addr_ack", {7'b0, ack}, 8'h01);
        write_byte(8'h06, ack); check("pw_reg_ack", {7'b0, ack}, 8'h01);
        send_bits(8'hF0, 4);
        i2c_stop();
        exp_q.push_back(8'h22);
        rd_regs(8'h06, 1);

        // Burst read of LED then switches.
        sw_in = 8'hA5;
        #Q;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hA5);
        rd_regs(8'h20, 2);

        // Reset mid-byte while the target drives SDA low.
        i2c_start();
        write_byte(8'hA0, ack); check("rr_addr_ack", {7'b0, ack}, 8'h01);
        write_byte(8'h01, ack); check("rr_reg_ack", {7'b0, ack}, 8'h01);
        i2c_start();
        write_byte(8'hA1, ack); check("rr_raddr_ack", {7'b0, ack}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            #Q; scl_m = 1'b1;
            #(2*Q); scl_m = 1'b0;
        end
        #Q;
        check("rr_driving", {7'b0, sda_oe}, 8'h01);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        check("rr_release", {7'b0, sda_oe}, 8'h00);
        repeat (4) @(posedge clk);
        scl_m = 1'b1;
        sda_m = 1'b1;
        @(negedge clk) rst = 1'b0;
        #(4*Q);
        check("rr_led_reset", led_out, 8'h00);
        exp_q.push_back(8'hA7);
        rd_regs(8'h00, 1);
        exp_q.push_back(8'h00);
        rd_regs(8'h05, 1);

        check("scoreboard_drained", exp_q.size()[7:0], 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
